// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped store sink: default bus
// addresses, control command codes and the sink state encoding.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_DATA_ADDR = 32'd84;
    localparam logic [31:0] DEFAULT_CTRL_ADDR = 32'd88;

    localparam logic [1:0] CMD_HALT  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } sink_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; DEPTH must be a power
// of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; occupancy gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_store_sink.sv
// Store sink on the CPU data bus: data-address stores feed a FIFO, control-address
// stores halt or clear. Optional pass comparator enabled by MMIO_SINK_CHECK_EN.
module mmio_store_sink
    import mmio_pkg::*;
#(
    parameter logic [31:0] DATA_ADDR    = DEFAULT_DATA_ADDR,
    parameter logic [31:0] CTRL_ADDR    = DEFAULT_CTRL_ADDR,
    parameter int unsigned DEPTH        = 8,
    parameter logic [31:0] EXPECT_VALUE = 32'h96
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memwrite,
    input  logic [31:0]            dataadr,
    input  logic [31:0]            writedata,
    output logic                   hit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic                   done,
    output logic                   pass
);

    sink_state_t state_q, state_d;
    logic        overflow_q, overflow_d;
    logic        data_wr, ctrl_wr;
    logic        cmd_halt, cmd_clear;
    logic        sink_open;
    logic        fifo_pop, fifo_push, fifo_empty;
    logic        drop_full;
    logic [31:0] fifo_rdata;

    assign data_wr   = memwrite && (dataadr == DATA_ADDR);
    assign ctrl_wr   = memwrite && (dataadr == CTRL_ADDR);
    assign hit       = data_wr || ctrl_wr;
    assign cmd_halt  = ctrl_wr && (writedata[1:0] == CMD_HALT);
    assign cmd_clear = ctrl_wr && (writedata[1:0] == CMD_CLEAR);

    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = data_wr && sink_open && (!full || fifo_pop);
    assign drop_full = data_wr && sink_open && full && !fifo_pop;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (cmd_clear),
        .wdata (writedata),
        .rdata (fifo_rdata),
        .count (count),
        .full  (full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cmd_clear) begin
            state_d = IDLE;
        end else if (cmd_halt && state_q != HALTED) begin
            state_d = HALTED;
        end else if (fifo_push && state_q == IDLE) begin
            state_d = RUN;
        end
    end

    always_comb begin
        done      = (state_q == HALTED);
        sink_open = (state_q != HALTED);
    end

    assign overflow_d = cmd_clear ? 1'b0 : (overflow_q || drop_full);

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;

`ifdef MMIO_SINK_CHECK_EN
    logic pass_q, pass_d;

    // Only stores that actually enter the FIFO can set pass.
    assign pass_d = cmd_clear ? 1'b0 : (pass_q || (fifo_push && writedata == EXPECT_VALUE));

    always_ff @(posedge clk) begin
        if (reset) pass_q <= 1'b0;
        else       pass_q <= pass_d;
    end

    assign pass = pass_q;
`else
    logic unused_expect;
    assign unused_expect = ^EXPECT_VALUE;
    assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_store_sink.sv
// Self-checking bench for mmio_store_sink: directed scenarios plus randomized
// bus traffic compared against a queue-based reference model.
module tb_mmio_store_sink;

    localparam int          DEPTH = 8;
    localparam logic [31:0] DADR  = 32'd84;
    localparam logic [31:0] CADR  = 32'd88;
    localparam logic [31:0] EXPV  = 32'h96;

    logic        clk = 1'b0;
    logic        reset, memwrite, out_ready;
    logic [31:0] dataadr, writedata;
    logic        hit, out_valid, full, overflow, done, pass;
    logic [31:0] out_data;
    logic [3:0]  count;

    always #5 clk = ~clk;

    mmio_store_sink #(
        .DATA_ADDR    (DADR),
        .CTRL_ADDR    (CADR),
        .DEPTH        (DEPTH),
        .EXPECT_VALUE (EXPV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .hit       (hit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .done      (done),
        .pass      (pass)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: contents as a queue, plus the observable flags.
    logic [31:0] mq[$];
    bit m_ovf, m_pass, m_halted;

    task automatic model_update(input bit rst, input bit mw, input logic [31:0] adr,
                                input logic [31:0] wd, input bit rdy);
        bit popping, was_full;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_pass = 0; m_halted = 0;
            return;
        end
        popping  = rdy && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        if (mw && adr == CADR && wd[1:0] == 2'b10) begin
            mq.delete();
            m_ovf = 0; m_pass = 0; m_halted = 0;
            return;
        end
        if (popping) void'(mq.pop_front());
        if (mw && adr == CADR && wd[1:0] == 2'b01) m_halted = 1;
        if (mw && adr == DADR && !m_halted) begin
            if (!was_full || popping) begin
                mq.push_back(wd);
                if (wd == EXPV) m_pass = 1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        bit exp_pass;
`ifdef MMIO_SINK_CHECK_EN
        exp_pass = m_pass;
`else
        exp_pass = 0;
`endif
        check({pfx, "_out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check({pfx, "_out_data"},  out_data, (mq.size() != 0) ? mq[0] : 32'd0);
        check({pfx, "_count"},     32'(count), 32'(mq.size()));
        check({pfx, "_full"},      32'(full), 32'(mq.size() == DEPTH));
        check({pfx, "_overflow"},  32'(overflow), 32'(m_ovf));
        check({pfx, "_done"},      32'(done), 32'(m_halted));
        check({pfx, "_pass"},      32'(pass), 32'(exp_pass));
    endtask

    // One bus cycle: drive, check hit combinationally, clock, then check state.
    task automatic step(input string pfx, input bit rst, input bit mw,
                        input logic [31:0] adr, input logic [31:0] wd, input bit rdy);
        reset = rst; memwrite = mw; dataadr = adr; writedata = wd; out_ready = rdy;
        #1;
        check({pfx, "_hit"}, 32'(hit), 32'(mw && (adr == DADR || adr == CADR)));
        @(posedge clk);
        model_update(rst, mw, adr, wd, rdy);
        #1;
        check_outputs(pfx);
    endtask

    task automatic do_reset(input string pfx);
        step(pfx, 1, 0, 32'd0, 32'd0, 0);
    endtask

    initial begin
        int ready_pct;
        int r;
        do_reset("rst");
        check("rst_out_data_zero", out_data, 32'd0);
        check("rst_count_zero", 32'(count), 32'd0);

        // Three stores, then drain in order.
        step("t1", 0, 1, DADR, 32'h11, 0);
        step("t1", 0, 1, DADR, 32'h22, 0);
        step("t1", 0, 1, DADR, 32'h33, 0);
        check("t1_count3", 32'(count), 32'd3);
        check("t1_head", out_data, 32'h11);
        step("t1", 0, 0, 32'd0, 32'd0, 1);
        check("t1_second", out_data, 32'h22);
        step("t1", 0, 0, 32'd0, 32'd0, 1);
        check("t1_third", out_data, 32'h33);
        step("t1", 0, 0, 32'd0, 32'd0, 1);
        check("t1_empty_valid", 32'(out_valid), 32'd0);
        check("t1_empty_data", out_data, 32'd0);

        // Nine stores into eight entries: the ninth is dropped.
        do_reset("t2r");
        for (int i = 1; i <= 9; i++) step("t2", 0, 1, DADR, 32'(i), 0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_count8", 32'(count), 32'd8);
        check("t2_overflow", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("t2_drain", out_data, 32'(i));
            step("t2", 0, 0, 32'd0, 32'd0, 1);
        end
        check("t2_drained", 32'(out_valid), 32'd0);

        // Full FIFO: a push with a simultaneous pop is accepted.
        do_reset("t3r");
        for (int i = 0; i < 8; i++) step("t3", 0, 1, DADR, 32'h100 + 32'(i), 0);
        step("t3", 0, 1, DADR, 32'h1FF, 1);
        check("t3_count8", 32'(count), 32'd8);
        check("t3_no_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 7; i++) step("t3", 0, 0, 32'd0, 32'd0, 1);
        check("t3_last", out_data, 32'h1FF);
        step("t3", 0, 0, 32'd0, 32'd0, 1);

        // Pass, halt, ignored store while halted, clear.
        do_reset("t4r");
        step("t4", 0, 1, DADR, EXPV, 0);
`ifdef MMIO_SINK_CHECK_EN
        check("t4_pass", 32'(pass), 32'd1);
`else
        check("t4_pass", 32'(pass), 32'd0);
`endif
        step("t4", 0, 1, CADR, 32'h1, 0);
        check("t4_done", 32'(done), 32'd1);
        step("t4", 0, 1, DADR, 32'h55, 0);
        check("t4_halted_count", 32'(count), 32'd1);
        check("t4_halted_no_ovf", 32'(overflow), 32'd0);
        step("t4", 0, 1, CADR, 32'h2, 0);
        check("t4_clr_count", 32'(count), 32'd0);
        check("t4_clr_pass", 32'(pass), 32'd0);
        check("t4_clr_done", 32'(done), 32'd0);

        // Foreign address, then reset with entries queued.
        step("t5", 0, 1, 32'd80, 32'h77, 0);
        check("t5_miss_count", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) step("t5", 0, 1, DADR, 32'h200 + 32'(i), 0);
        check("t5_count5", 32'(count), 32'd5);
        do_reset("t5r");
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_count", 32'(count), 32'd0);

        // Randomized traffic with varying consumer back-pressure.
        ready_pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] wd;
            bit rdy;
            if (cyc % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: ready_pct = 10;
                    1: ready_pct = 50;
                    2: ready_pct = 90;
                    default: ready_pct = 100;
                endcase
            end
            rdy = ($urandom_range(0, 99) < ready_pct);
            wd  = ($urandom_range(0, 15) == 0) ? EXPV : $urandom;
            r   = $urandom_range(0, 999);
            if (r < 3)        step("rnd", 1, 0, 32'd0, 32'd0, rdy);
            else if (r < 550) step("rnd", 0, 1, DADR, wd, rdy);
            else if (r < 620) step("rnd", 0, 1, CADR, {30'($urandom), 2'($urandom_range(0, 3))}, rdy);
            else if (r < 700) step("rnd", 0, 1, ($urandom_range(0, 1) != 0) ? 32'd80 : $urandom, wd, rdy);
            else if (r < 750) step("rnd", 0, 0, DADR, wd, rdy);
            else              step("rnd", 0, 0, 32'd0, 32'd0, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
